adc_spi_reader: RTL and testbench
=================================

Name: adc_spi_reader

Overview:
- Serial-interface master for the board's 12-bit LTC2308-style ADC, driving its CONVST/SCK/SDI pins and capturing SDO.
- Produces the 12-bit light-sensor voltage samples that the max-value comparator/register chain consumes, one sample per start request, with a single-cycle valid strobe.
- Sits between the ADC pins and the sunflower tracking logic.

Parameters:
CLK_DIV, 2, SCK half-period in clk cycles (legal >= 1)
CONV_CYCLES, 80, clk cycles CONVST is held high for ADC conversion (1.6 us at 50 MHz; legal >= 1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request one conversion+readout; sampled only in IDLE
channel  input  3  ADC channel for the config word sent in this transaction
busy  output  1  high in every state except IDLE
sample  output  12  last captured result, MSB first from SDO; held until next capture
sample_valid  output  1  one-cycle pulse when sample/sample_ch update
sample_ch  output  3  channel the captured sample belongs to (config from previous transaction)
adc_convst  output  1  ADC conversion start
adc_sck  output  1  ADC serial clock, idles low
adc_sdi  output  1  ADC config data, MSB first
adc_sdo  input  1  ADC result data

Behaviour:
- Reset (synchronous, wins over everything, any state): state=IDLE; busy=0, sample=0, sample_valid=0, sample_ch=0, adc_convst=0, adc_sck=0, adc_sdi=0; internal prev_ch=0; in-flight transaction discarded, no valid pulse.
- FSM states: IDLE, CONV, SHIFT, DONE.
- IDLE: busy=0. On start=1 at edge E0: latch channel into cur_ch, build cfg[5:0] = {1'b1 (single-ended), cur_ch[0], cur_ch[2], cur_ch[1], 1'b1 (unipolar), 1'b0 (no sleep)}, go CONV. start=0: stay.
- CONV: adc_convst=1 for exactly CONV_CYCLES cycles, then adc_convst=0, go SHIFT. SCK low throughout.
- SHIFT: 12 SCK periods, each 2*CLK_DIV clk cycles; each period is CLK_DIV cycles low then CLK_DIV cycles high.
  - adc_sdi is updated while SCK is low: period k (0..5) drives cfg[5-k]; periods 6..11 drive 0.
  - adc_sdo is sampled on the clk edge where adc_sck rises. It is shifted into bit 11-k of the shift register.
  - After the 12th high phase, adc_sck returns low and the FSM goes to DONE.
- DONE (1 cycle): sample <= shift register, sample_ch <= prev_ch, prev_ch <= cur_ch, sample_valid=1, busy=1, adc_sdi=0; next state IDLE.
- Latency: the first sample_valid high cycle begins CONV_CYCLES + 24*CLK_DIV + 1 edges after E0. With the defaults this is 129.
- The ADC returns the result of the conversion configured by the previous transaction. Therefore sample_ch reports the previous transaction's channel. The first sample after reset reports sample_ch=0.
- start while busy (CONV/SHIFT/DONE) is ignored; it is not queued. channel changes while busy have no effect.
- Back-to-back: start held high gives sample_valid every CONV_CYCLES + 24*CLK_DIV + 2 cycles (one IDLE cycle between transactions).
- sample_valid is never high two consecutive cycles.
- All ADC pin outputs are registered (no combinational path from adc_sdo or start to outputs).

Test Plan:
- Reset mid-SHIFT (CONV_CYCLES=4, CLK_DIV=1): assert reset during 5th SCK period -> next cycle all outputs 0, state IDLE, no sample_valid ever for that transaction.
- Single read, CONV_CYCLES=4, CLK_DIV=1, ADC model returns 12'hA5C, channel=3'd5 -> adc_convst high exactly 4 cycles; 12 SCK pulses; adc_sdi bits 1,1,1,0,1,0 on periods 0..5; sample_valid at edge E0+29 with sample=12'hA5C, sample_ch=0.
- Channel pipelining: three reads with channel 1, 2, 7, each model result = 12'h100+channel-of-previous-config -> sample_ch 0, 1, 2 respectively; sample values consistent.
- start held high continuously for 3 transactions (defaults) -> sample_valid pulses spaced exactly 130 cycles; busy low exactly 1 cycle between transactions.
- start pulsed during CONV and SHIFT -> no extra transaction; exactly one sample_valid.
- Boundary data: model returns 12'hFFF then 12'h000 with CLK_DIV=3 -> sample equals each exactly; each SCK high/low phase measures 3 cycles.

Source files
------------

// File: rtl/adc_spi_reader.sv
// rtl/adc_spi_reader.sv - LTC2308-style ADC serial master: conversion start, config shift-out, 12-bit readout
module adc_spi_reader #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  channel,
  output logic        busy,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic [2:0]  sample_ch,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] conv_cnt;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [5:0]    cfg;      // config bits still to send; MSB is the next one out
  logic [2:0]    cur_ch;   // channel configured by the transaction in flight
  logic [2:0]    prev_ch;  // channel whose conversion the ADC is returning now
  logic [11:0]   shreg;

  // Transaction sequencer: convert, shift config out while shifting the result in, publish
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      conv_cnt     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      cfg          <= '0;
      cur_ch       <= '0;
      prev_ch      <= '0;
      shreg        <= '0;
      busy         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      adc_convst   <= 1'b0;
      adc_sck      <= 1'b0;
      adc_sdi      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_ch     <= channel;
            // single-ended, odd/sign, select1, select0, unipolar, no sleep
            cfg        <= {1'b1, channel[0], channel[2], channel[1], 1'b1, 1'b0};
            conv_cnt   <= '0;
            adc_convst <= 1'b1;
            adc_sdi    <= 1'b0;
            busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          if (conv_cnt == CONV_LAST) begin
            adc_convst <= 1'b0;
            adc_sdi    <= cfg[5];
            div_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= SHIFT;
          end else begin
            conv_cnt <= conv_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!adc_sck) begin
              // rising SCK: SDO is stable since the previous falling edge
              adc_sck <= 1'b1;
              shreg   <= {shreg[10:0], adc_sdo};
            end else begin
              // falling SCK: present the next config bit (zeros once cfg drains)
              adc_sck <= 1'b0;
              cfg     <= {cfg[4:0], 1'b0};
              adc_sdi <= cfg[4];
              if (bit_cnt == 4'd11) begin
                state <= DONE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
        DONE: begin
          sample       <= shreg;
          sample_ch    <= prev_ch;
          prev_ch      <= cur_ch;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          adc_sdi      <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_reader.sv
// tb/tb_adc_spi_reader.sv - checks adc_spi_reader against a transaction-level model and directed literals
module tb_adc_spi_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_v    [3];
  logic [2:0]  channel_v  [3];
  logic        busy_v     [3];
  logic [11:0] sample_v   [3];
  logic        valid_v    [3];
  logic [2:0]  sch_v      [3];
  logic        convst_v   [3];
  logic        sck_v      [3];
  logic        sdi_v      [3];
  logic        sdo_v      [3];
  logic [11:0] adc_result [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic int conv_of(input int i);
    return (i == 1) ? 80 : 4;
  endfunction

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // DUT 0: CONV 4 / DIV 1, DUT 1: defaults, DUT 2: CONV 4 / DIV 3; each with its own ADC model
  for (genvar g = 0; g < 3; g++) begin : g_dut
    adc_spi_reader #(
      .CLK_DIV    (g == 0 ? 1 : (g == 1 ? 2 : 3)),
      .CONV_CYCLES(g == 1 ? 80 : 4)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start_v[g]),
      .channel     (channel_v[g]),
      .busy        (busy_v[g]),
      .sample      (sample_v[g]),
      .sample_valid(valid_v[g]),
      .sample_ch   (sch_v[g]),
      .adc_convst  (convst_v[g]),
      .adc_sck     (sck_v[g]),
      .adc_sdi     (sdi_v[g]),
      .adc_sdo     (sdo_v[g])
    );

    logic [11:0] adc_sh = 12'h000;
    logic        conv_last = 1'b0;
    assign sdo_v[g] = adc_sh[11];

    // ADC: result loads MSB-first when CONVST falls, next bit on each SCK falling edge
    always @(convst_v[g] or negedge sck_v[g]) begin
      if (convst_v[g] !== conv_last) begin
        if (conv_last === 1'b1 && convst_v[g] === 1'b0) adc_sh = adc_result[g];
        conv_last = convst_v[g];
      end else if (convst_v[g] === 1'b0) begin
        adc_sh = {adc_sh[10:0], 1'b0};
      end
    end
  end

  // Transaction model: ph = clock edges since the accepting edge, -1 when idle
  int          ph     [3];
  logic [2:0]  m_prev [3];
  logic [2:0]  m_cur  [3];
  logic [5:0]  m_cfg  [3];
  logic [11:0] e_sample [3];
  logic [2:0]  e_ch   [3];
  logic        e_valid [3];
  logic        m_ready = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        ph[i] = -1; m_prev[i] = 3'd0; m_cur[i] = 3'd0; m_cfg[i] = 6'd0;
        e_sample[i] = 12'd0; e_ch[i] = 3'd0; e_valid[i] = 1'b0;
      end else begin
        e_valid[i] = 1'b0;
        if (ph[i] < 0) begin
          if (start_v[i]) begin
            ph[i] = 0;
            m_cur[i] = channel_v[i];
            m_cfg[i] = {1'b1, channel_v[i][0], channel_v[i][2], channel_v[i][1], 1'b1, 1'b0};
          end
        end else begin
          ph[i] = ph[i] + 1;
          if (ph[i] == conv_of(i) + 24 * div_of(i) + 1) begin
            e_valid[i] = 1'b1;
            e_sample[i] = adc_result[i];
            e_ch[i] = m_prev[i];
            m_prev[i] = m_cur[i];
            ph[i] = -1;
          end
        end
      end
    end
    if (reset) m_ready = 1'b1;
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (m_ready) begin
      for (int i = 0; i < 3; i++) begin
        int c, d, s, k;
        logic eb, ec, es, ed;
        c = conv_of(i); d = div_of(i);
        eb = 1'b0; ec = 1'b0; es = 1'b0; ed = 1'b0;
        if (ph[i] >= 0) begin
          eb = 1'b1;
          ec = (ph[i] < c);
          s = ph[i] - c;
          if (s >= 0 && s < 24 * d) begin
            es = ((s / d) % 2) == 1;
            k = s / (2 * d);
            ed = (k < 6) ? m_cfg[i][5 - k] : 1'b0;
          end
        end
        chk("cyc_busy",   i, busy_v[i],   eb);
        chk("cyc_convst", i, convst_v[i], ec);
        chk("cyc_sck",    i, sck_v[i],    es);
        chk("cyc_sdi",    i, sdi_v[i],    ed);
        chk("cyc_valid",  i, valid_v[i],  e_valid[i]);
        chk("cyc_sample", i, sample_v[i], e_sample[i]);
        chk("cyc_ch",     i, sch_v[i],    e_ch[i]);
      end
    end
  end

  task automatic check_idle(input string name, input int i);
    chk({name, "_busy"},   i, busy_v[i],   0);
    chk({name, "_valid"},  i, valid_v[i],  0);
    chk({name, "_sample"}, i, sample_v[i], 0);
    chk({name, "_ch"},     i, sch_v[i],    0);
    chk({name, "_convst"}, i, convst_v[i], 0);
    chk({name, "_sck"},    i, sck_v[i],    0);
    chk({name, "_sdi"},    i, sdi_v[i],    0);
  endtask

  // One transaction; returns measurements taken on the pins, ends on the valid cycle
  task automatic run_txn(input int i, input logic [2:0] ch, input logic [11:0] res,
                         output int lat, output int conv_n, output int rises,
                         output logic [5:0] cfg_seen, output int min_ph, output int max_ph);
    int run;
    logic last_sck;
    adc_result[i] = res;
    @(negedge clk);
    channel_v[i] = ch;
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    lat = 0; conv_n = 0; rises = 0; cfg_seen = 6'd0; min_ph = 1000; max_ph = 0;
    run = 0; last_sck = 1'b0;
    while (!valid_v[i] && lat < 5000) begin
      if (convst_v[i]) begin
        conv_n++;
        run = 0;
      end else if (sck_v[i] != last_sck) begin
        if (run < min_ph) min_ph = run;
        if (run > max_ph) max_ph = run;
        if (sck_v[i] && rises < 6) cfg_seen = {cfg_seen[4:0], sdi_v[i]};
        if (sck_v[i]) rises++;
        run = 1;
      end else begin
        run++;
      end
      last_sck = sck_v[i];
      @(negedge clk);
      lat++;
    end
    chk("txn_valid_seen", i, valid_v[i], 1);
  endtask

  initial begin
    int lat, conv_n, rises, min_ph, max_ph, nv, t, last_t, pulses, bl;
    logic [5:0] cfg_seen;
    logic [11:0] pipe_res [3];
    logic [2:0]  pipe_ch  [3];

    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; channel_v[i] = 3'd0; adc_result[i] = 12'd0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle("reset", i);
    reset = 1'b0;

    // Single read, CONV 4 / DIV 1, channel 5
    run_txn(0, 3'd5, 12'hA5C, lat, conv_n, rises, cfg_seen, min_ph, max_ph);
    chk("single_latency", 0, lat, 29);
    chk("single_convst_cycles", 0, conv_n, 4);
    chk("single_sck_pulses", 0, rises, 12);
    chk("single_cfg_bits", 0, cfg_seen, 6'b111010);
    chk("single_sample", 0, sample_v[0], 12'hA5C);
    chk("single_ch", 0, sch_v[0], 3'd0);
    chk("single_phase_min", 0, min_ph, 1);
    chk("single_phase_max", 0, max_ph, 1);

    // Channel pipelining from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pipe_ch[0] = 3'd1; pipe_ch[1] = 3'd2; pipe_ch[2] = 3'd7;
    pipe_res[0] = 12'h100; pipe_res[1] = 12'h101; pipe_res[2] = 12'h102;
    for (int n = 0; n < 3; n++) begin
      run_txn(0, pipe_ch[n], pipe_res[n], lat, conv_n, rises, cfg_seen, min_ph, max_ph);
      chk("pipe_sample", 0, sample_v[0], pipe_res[n]);
      chk("pipe_ch", 0, sch_v[0], n);
    end

    // Reset during the 5th SCK period discards the transaction
    adc_result[0] = 12'h3C3;
    @(negedge clk);
    channel_v[0] = 3'd4;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("rst_shift", 0);
    nv = 0;
    repeat (60) begin
      @(negedge clk);
      if (valid_v[0]) nv++;
    end
    chk("rst_shift_no_valid", 0, nv, 0);

    // start pulses during CONV and SHIFT are ignored
    adc_result[0] = 12'h5A5;
    @(negedge clk);
    channel_v[0] = 3'd6;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    nv = 0;
    for (int l = 1; l <= 80; l++) begin
      @(negedge clk);
      start_v[0] = (l == 2 || l == 10);
      if (valid_v[0]) nv++;
    end
    start_v[0] = 1'b0;
    chk("busy_start_one_valid", 0, nv, 1);
    chk("busy_start_sample", 0, sample_v[0], 12'h5A5);

    // Back-to-back with start held high, default parameters
    adc_result[1] = 12'h777;
    @(negedge clk);
    channel_v[1] = 3'd3;
    start_v[1] = 1'b1;
    t = 0; pulses = 0; bl = 0; last_t = 0;
    while (pulses < 3 && t < 1000) begin
      @(negedge clk);
      t++;
      if (!busy_v[1]) bl++;
      if (valid_v[1]) begin
        if (pulses == 0) chk("b2b_first_latency", 1, t, 130);
        else begin
          chk("b2b_spacing", 1, t - last_t, 130);
          chk("b2b_busy_low", 1, bl, 1);
        end
        chk("b2b_sample", 1, sample_v[1], 12'h777);
        last_t = t; bl = 0; pulses++;
        if (pulses == 3) start_v[1] = 1'b0;
      end
    end
    start_v[1] = 1'b0;
    chk("b2b_pulses", 1, pulses, 3);
    repeat (4) @(negedge clk);

    // Boundary data with CLK_DIV 3
    run_txn(2, 3'd0, 12'hFFF, lat, conv_n, rises, cfg_seen, min_ph, max_ph);
    chk("div3_latency", 2, lat, 77);
    chk("div3_sample_fff", 2, sample_v[2], 12'hFFF);
    chk("div3_phase_min", 2, min_ph, 3);
    chk("div3_phase_max", 2, max_ph, 3);
    chk("div3_sck_pulses", 2, rises, 12);
    chk("div3_cfg_ch0", 2, cfg_seen, 6'b100010);
    run_txn(2, 3'd3, 12'h000, lat, conv_n, rises, cfg_seen, min_ph, max_ph);
    chk("div3_sample_000", 2, sample_v[2], 12'h000);
    chk("div3_cfg_ch3", 2, cfg_seen, 6'b110110);
    chk("div3_phase_min2", 2, min_ph, 3);
    chk("div3_phase_max2", 2, max_ph, 3);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
